// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the CPU MEM stage: accepts one load/store,
// stalls the pipeline for LATENCY cycles, then answers in a single RESP cycle.
module dmem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        stall
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(LATENCY - 1);

  state_t                state, state_d;
  logic [3:0]            cnt, cnt_d;
  logic                  accept;
  logic                  last_wait;

  logic [DEPTH_LOG2-1:0] idx_q;
  logic                  wr_q;
  logic [15:0]           wdata_q;

  logic [15:0]           mem [0:(1<<DEPTH_LOG2)-1];

  // Byte-offset bit and bits above the word index only alias; they never select.
  logic                  unused_addr_bits;
  assign unused_addr_bits = ^{addr[15:DEPTH_LOG2+1], addr[0]};

  // NOTE: every output of this block gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    stall     = 1'b0;
    accept    = 1'b0;
    last_wait = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable) begin
          stall   = 1'b1;
          accept  = 1'b1;
          cnt_d   = 4'd1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (cnt == LAST_CNT) begin
          last_wait = 1'b1;
          state_d   = S_RESP;
        end else begin
          cnt_d = cnt + 4'd1;
        end
      end
      // enable is still high here for the request just served; it is not re-accepted.
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (rst) stall = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      data_out   <= 16'h0000;
      data_valid <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      data_valid <= last_wait && !wr_q;
      if (last_wait && !wr_q) data_out <= mem[idx_q];
    end
  end

  // Request is captured once at acceptance; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q   <= addr[DEPTH_LOG2:1];
      wr_q    <= wr;
      wdata_q <= data_in;
    end
  end

  // NOTE: the array has no reset; its contents survive rst. A store pending in
  // RESP is dropped if rst arrives in that same cycle.
  always_ff @(posedge clk) begin
    if (!rst && state == S_RESP && wr_q) mem[idx_q] <= wdata_q;
  end

endmodule
